// File: rtl/draw_card.sv
// Card draw block: free-running 1..13 counter sampled on a rising edge of `in`, with 7-segment displays.
// Optional DRAW_CARD_FACE_CAP_EN: draws of 11..13 load card=10 (counter sequence unchanged).
module draw_card (
  input  logic       clock,
  input  logic       reset,
  input  logic       in,
  output logic [3:0] card,
  output logic       drawn,
  output logic [6:0] hex_tens,
  output logic [6:0] hex_ones,
  output logic [6:0] hex_raw
);

  localparam int unsigned CARD_W   = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned CARD_MIN = 1;
  localparam int unsigned CARD_MAX = 13;
  localparam int unsigned FACE_CAP = 10;

  logic [CARD_W-1:0] cnt;
  logic              in_d;
  logic              armed;
  logic              draw_evt;
  logic [CARD_W-1:0] draw_val;
  logic [CARD_W-1:0] tens_digit;
  logic [CARD_W-1:0] ones_digit;

  // Shared hex decoder, segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [SEG_W-1:0] seg7(input logic [CARD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A draw needs a sampled low since reset, so `in` held high through reset release is ignored.
  assign draw_evt = in & ~in_d & armed;

  always_comb begin
    draw_val = cnt;
`ifdef DRAW_CARD_FACE_CAP_EN
    if (cnt > CARD_W'(FACE_CAP)) draw_val = CARD_W'(FACE_CAP);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= CARD_W'(CARD_MIN);
      in_d  <= 1'b0;
      armed <= 1'b0;
      card  <= '0;
      drawn <= 1'b0;
    end else begin
      cnt   <= (cnt == CARD_W'(CARD_MAX)) ? CARD_W'(CARD_MIN) : cnt + CARD_W'(1);
      in_d  <= in;
      if (!in) armed <= 1'b1;
      drawn <= draw_evt;
      if (draw_evt) card <= draw_val;
    end
  end

  always_comb begin
    tens_digit = '0;
    ones_digit = card;
    if (card >= CARD_W'(10)) begin
      tens_digit = CARD_W'(1);
      ones_digit = card - CARD_W'(10);
    end
  end

  assign hex_tens = seg7(tens_digit);
  assign hex_ones = seg7(ones_digit);
  assign hex_raw  = seg7(card);

endmodule

// File: tb/tb_draw_card.sv
// Directed self-checking bench for draw_card; edges are counted from reset release.
module tb_draw_card;

  logic       clock;
  logic       reset;
  logic       in;
  logic [3:0] card;
  logic       drawn;
  logic [6:0] hex_tens;
  logic [6:0] hex_ones;
  logic [6:0] hex_raw;

  int checks = 0;
  int errors = 0;
  int pulses;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100001;

  draw_card dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .card     (card),
    .drawn    (drawn),
    .hex_tens (hex_tens),
    .hex_ones (hex_ones),
    .hex_raw  (hex_raw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic d,
                           input logic [6:0] t, input logic [6:0] o, input logic [6:0] r);
    check({tag, ".card"},  8'(card), 8'(c));
    check({tag, ".drawn"}, 8'(drawn), 8'(d));
    check({tag, ".tens"},  8'(hex_tens), 8'(t));
    check({tag, ".ones"},  8'(hex_ones), 8'(o));
    check({tag, ".raw"},   8'(hex_raw), 8'(r));
  endtask

  // Each step advances one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    in    = 1'b0;
    step(3);
    check_all("reset", 4'd0, 1'b0, S0, S0, S0);

    // First draw on the 5th edge after release
    reset = 1'b1;
    step(4);
    check("pre_draw.card", 8'(card), 8'd0);
    in = 1'b1;
    step(1);
    check_all("draw5", 4'd5, 1'b1, S0, S5, S5);

    // Held high: no further pulses, card stays
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (drawn) pulses++;
    end
    check("hold.pulses", 8'(pulses), 8'd0);
    check("hold.card", 8'(card), 8'd5);

    // One low edge (26) then high on edge 27 -> cnt 1
    in = 1'b0;
    step(1);
    in = 1'b1;
    step(1);
    check_all("redraw27", 4'd1, 1'b1, S0, S1, S1);

    // Asynchronous reset between edges clears immediately
    #2 reset = 1'b0;
    #1 check_all("async_rst", 4'd0, 1'b0, S0, S0, S0);
    in = 1'b0;
    step(2);

    // Draw on edge 13 -> cnt 13
    reset = 1'b1;
    step(12);
    in = 1'b1;
    step(1);
`ifdef DRAW_CARD_FACE_CAP_EN
    check_all("draw13", 4'd10, 1'b1, S1, S0, SA);
`else
    check_all("draw13", 4'd13, 1'b1, S1, S3, SD);
`endif
    step(1);
    check("draw13.drawn_off", 8'(drawn), 8'd0);

    // Draw on edge 14 -> counter wrapped to 1
    reset = 1'b0;
    in = 1'b0;
    step(1);
    reset = 1'b1;
    step(13);
    in = 1'b1;
    step(1);
    check_all("wrap14", 4'd1, 1'b1, S0, S1, S1);

    // in high through reset release: no draw until low then high
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(3);
    check("hi_release.card", 8'(card), 8'd0);
    check("hi_release.drawn", 8'(drawn), 8'd0);
    in = 1'b0;
    step(1);
    in = 1'b1;
    step(1);
    check_all("hi_release.draw5", 4'd5, 1'b1, S0, S5, S5);

    // Low on edges 6..10, draw on edge 11
    in = 1'b0;
    step(5);
    in = 1'b1;
    step(1);
`ifdef DRAW_CARD_FACE_CAP_EN
    check_all("draw11", 4'd10, 1'b1, S1, S0, SA);
`else
    check_all("draw11", 4'd11, 1'b1, S1, S1, SB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
